mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sits directly downstream of the pipelined datapath's instruction and data memory ports and merges them onto one single-ported physical memory interface.
- Replaces the dual-port magic memory, which always responded in one cycle.
- Grants one outstanding request at a time and holds its attributes stable until the memory responds.
- Data port has priority over instruction fetch (it belongs to the older instruction); a bounded-starvation counter guarantees fetch progress.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive data grants while an instruction request waits; the next grant then goes to the instruction port.
- ADDR_ALIGN, 1: 1 = force pmem_address[1:0] to 2'b00; 0 = pass the address through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_mem_read  in  1  fetch request; held high until instr_mem_resp
- instr_mem_address  in  32  fetch address
- instr_mem_resp  out  1  one-cycle fetch completion pulse
- instr_mem_rdata  out  32  fetch data; valid when instr_mem_resp=1
- data_mem_read  in  1  load request; held until data_mem_resp
- data_mem_write  in  1  store request; held until data_mem_resp
- data_mem_address  in  32  load/store address
- data_mem_wdata  in  32  store data
- mem_byte_enable  in  4  store byte mask
- data_mem_resp  out  1  one-cycle load/store completion pulse
- data_mem_rdata  out  32  load data; valid when data_mem_resp=1
- pmem_read  out  1  physical read strobe
- pmem_write  out  1  physical write strobe
- pmem_address  out  32  physical address
- pmem_wdata  out  32  physical write data
- pmem_byte_enable  out  4  physical byte mask
- pmem_resp  in  1  physical completion pulse
- pmem_rdata  in  32  physical read data

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-high, port named rst. In reset, the FSM goes to IDLE and streak_cnt clears to 0.
- Output values in reset and in IDLE: all pmem strobes 0, address/wdata 0, byte_enable 0, both resp 0, both rdata 0.
- States:
  - IDLE: evaluate requests.
  - BUSY_I: instruction request granted.
  - BUSY_D: data request granted.
- Grant rule in IDLE:
  - No request pending: stay in IDLE.
  - Data request pending (read or write) and (streak_cnt < MAX_D_STREAK or no fetch pending): go to BUSY_D.
  - Otherwise, if a fetch is pending: go to BUSY_I.
- Request latching on the grant edge:
  - Latch address, wdata, byte_enable and read/write type into holding registers.
  - pmem outputs are driven only from the holding registers. Upstream changes after the grant are ignored.
- data_mem_read and data_mem_write high together: illegal. Treat as a write; simulation assertion fires.
- pmem strobe behaviour:
  - The strobe is asserted from the first cycle in BUSY_* and held until the cycle pmem_resp=1 inclusive.
  - pmem_byte_enable is 4'b1111 for reads and mem_byte_enable for writes.
- Completion:
  - In the pmem_resp cycle, the granted port's resp=1 combinationally and its rdata=pmem_rdata. The store resp carries rdata 0.
  - Next state is IDLE. Minimum turnaround is one IDLE cycle between transactions, so a requester's resp-cycle request is never re-granted.
- Latency: request seen in IDLE at cycle N → pmem strobe at N+1 → resp in the same cycle as pmem_resp. Best case is 2 cycles.
- streak_cnt (width clog2(MAX_D_STREAK+1)):
  - Data grant while a fetch is pending: increment, saturating.
  - Any instruction grant: clear to 0.
  - Data grant with no fetch pending: clear to 0.
- Non-granted port: resp stays 0 throughout. Its request remains pending and is evaluated at the next IDLE.
- pmem_resp outside BUSY_*: ignored. No resp is generated and no state change occurs.
- Reset mid-transaction: the transaction is abandoned, strobes drop the next cycle and no resp is issued. Requesters reissue.
- Address: if ADDR_ALIGN=1, pmem_address[1:0] is forced to 0.

Test Plan:
- Single fetch: instr_mem_read=1, addr 0x60; pmem_resp at cycle 3, rdata 0x00A00093 → pmem_read=1, addr 0x60 from cycle 1; instr_mem_resp=1, rdata 0x00A00093 at cycle 3; IDLE at cycle 4.
- Simultaneous: fetch 0x64 and load 0x1000 in the same cycle → data granted first, instr_mem_resp stays 0; fetch granted in the IDLE after data_mem_resp.
- Store: data_mem_write, addr 0x2002, wdata 0x0000BEEF, mask 4'b1100 → pmem_write=1, pmem_byte_enable=4'b1100, pmem_address=0x2000; data_mem_resp pulses once.
- Starvation bound: fetch held high, back-to-back loads with MAX_D_STREAK=4 → exactly 4 data grants, then 1 instruction grant, then data resumes.
- Reset during BUSY_D (rst high one cycle before pmem_resp) → strobes 0 the next cycle, no data_mem_resp, streak_cnt=0; a late pmem_resp is ignored.
- Upstream address changes from 0x100 to 0x200 mid-BUSY_I → pmem_address remains 0x100 until the resp cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Merges instruction-fetch and data ports onto one single-ported memory, one transaction at a time.
// Latency: request seen in IDLE at N, strobe from N+1, resp combinational with pmem_resp.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter bit ADDR_ALIGN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_mem_read,
    input  logic [31:0] instr_mem_address,
    output logic        instr_mem_resp,
    output logic [31:0] instr_mem_rdata,
    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic        data_mem_resp,
    output logic [31:0] data_mem_rdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    input  logic        pmem_resp,
    input  logic [31:0] pmem_rdata
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [SW-1:0] r_streak;
    logic [SW-1:0] w_streak_nxt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          r_wr;

    logic w_fetch_pend;
    logic w_data_pend;
    logic w_grant_i;
    logic w_grant_d;
    logic w_busy;

    assign w_fetch_pend = instr_mem_read;
    assign w_data_pend  = data_mem_read | data_mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_streak <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_wr     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_streak <= w_streak_nxt;
            // Simultaneous read+write is illegal upstream; the write wins.
            if (w_grant_d) begin
                r_addr  <= data_mem_address;
                r_wr    <= data_mem_write;
                r_wdata <= data_mem_write ? data_mem_wdata : 32'h0;
                r_be    <= data_mem_write ? mem_byte_enable : 4'hF;
            end else if (w_grant_i) begin
                r_addr  <= instr_mem_address;
                r_wr    <= 1'b0;
                r_wdata <= 32'h0;
                r_be    <= 4'hF;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        w_grant_i        = 1'b0;
        w_grant_d        = 1'b0;
        w_streak_nxt     = r_streak;
        w_busy           = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = 32'h0;
        pmem_wdata       = 32'h0;
        pmem_byte_enable = 4'h0;
        instr_mem_resp   = 1'b0;
        instr_mem_rdata  = 32'h0;
        data_mem_resp    = 1'b0;
        data_mem_rdata   = 32'h0;

        case (r_state)
            IDLE: begin
                if (w_data_pend && ((r_streak < SW'(MAX_D_STREAK)) || !w_fetch_pend)) begin
                    w_next    = BUSY_D;
                    w_grant_d = 1'b1;
                end else if (w_fetch_pend) begin
                    w_next    = BUSY_I;
                    w_grant_i = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_resp) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase

        if (w_grant_i) begin
            w_streak_nxt = '0;
        end else if (w_grant_d) begin
            if (!w_fetch_pend)
                w_streak_nxt = '0;
            else if (r_streak != SW'(MAX_D_STREAK))
                w_streak_nxt = r_streak + SW'(1);
        end

        // Outputs are forced quiet while reset is asserted, abandoning any transaction.
        w_busy = !rst && (r_state != IDLE);
        if (w_busy) begin
            pmem_read        = !r_wr;
            pmem_write       = r_wr;
            pmem_address     = {r_addr[31:2], (ADDR_ALIGN ? 2'b00 : r_addr[1:0])};
            pmem_wdata       = r_wdata;
            pmem_byte_enable = r_be;
            if (pmem_resp && (r_state == BUSY_I)) begin
                instr_mem_resp  = 1'b1;
                instr_mem_rdata = pmem_rdata;
            end
            if (pmem_resp && (r_state == BUSY_D)) begin
                data_mem_resp  = 1'b1;
                data_mem_rdata = r_wr ? 32'h0 : pmem_rdata;
            end
        end
    end

    a_no_rw_together: assert property (@(posedge clk) disable iff (rst)
        !(data_mem_read && data_mem_write));

endmodule
